// File: rtl/div_ratio_detector.sv
// div_ratio_detector: measures a divided clock's period, recovers its divide select, flags lock/change/stall
module div_ratio_detector #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 6,
    parameter int LOCK_COUNT  = 3
) (
    input  logic                 Clock_in,
    input  logic                 Reset,
    input  logic                 Clock_div,
    output logic [1:0]           Sel_out,
    output logic                 Locked,
    output logic [CNT_WIDTH-1:0] Period,
    output logic                 Error
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam int MW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {IDLE, FIRST, CHECK, LOCKED} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s_prev, rise, legal, timeout;
    logic [CNT_WIDTH-1:0]   cnt, period_nxt, cand_per, sel_per;
    logic [1:0]             code, cand, cand_nxt, sel_nxt;
    logic [MW-1:0]          match, match_nxt;
    logic                   locked_nxt, error_nxt;

    // synchronize the divided clock and keep one delayed copy for rise detection
    always_ff @(posedge Clock_in or negedge Reset) begin
        if (!Reset) begin
            sync   <= '0;
            s_prev <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], Clock_div};
            s_prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~s_prev;

    // period counter: restarts at 1 on each rise so it reads P on the next one, saturates otherwise
    always_ff @(posedge Clock_in or negedge Reset) begin
        if (!Reset)
            cnt <= '0;
        else
            cnt <= rise ? CNT_WIDTH'(1) : (cnt == CNT_MAX ? cnt : cnt + 1'b1);
    end

    assign legal    = cnt == CNT_WIDTH'(2) || cnt == CNT_WIDTH'(4) ||
                      cnt == CNT_WIDTH'(8) || cnt == CNT_WIDTH'(16);
    assign code     = cnt == CNT_WIDTH'(4)  ? 2'b01 :
                      cnt == CNT_WIDTH'(8)  ? 2'b10 :
                      cnt == CNT_WIDTH'(16) ? 2'b11 : 2'b00;
    assign cand_per = CNT_WIDTH'(2) << cand;
    assign sel_per  = CNT_WIDTH'(2) << Sel_out;
    assign timeout  = state != IDLE && !rise && cnt == CNT_MAX;

    // FSM state and registered outputs
    always_ff @(posedge Clock_in or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            cand    <= 2'b00;
            match   <= '0;
            Sel_out <= 2'b00;
            Locked  <= 1'b0;
            Period  <= '0;
            Error   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cand    <= cand_nxt;
            match   <= match_nxt;
            Sel_out <= sel_nxt;
            Locked  <= locked_nxt;
            Period  <= period_nxt;
            Error   <= error_nxt;
        end
    end

    // next state: a stalled divided clock wins over everything, otherwise act only on rise cycles
    always_comb begin
        state_nxt  = state;
        cand_nxt   = cand;
        match_nxt  = match;
        sel_nxt    = Sel_out;
        locked_nxt = Locked;
        period_nxt = Period;
        error_nxt  = 1'b0;
        if (timeout) begin
            state_nxt  = IDLE;
            locked_nxt = 1'b0;
            error_nxt  = 1'b1;
        end else if (rise) begin
            if (state != IDLE)
                period_nxt = cnt;
            unique case (state)
                IDLE: state_nxt = FIRST;
                FIRST: begin
                    if (legal) begin
                        cand_nxt  = code;
                        match_nxt = MW'(1);
                        state_nxt = CHECK;
                    end else begin
                        error_nxt = 1'b1;
                    end
                end
                CHECK: begin
                    if (cnt == cand_per) begin
                        match_nxt = match + 1'b1;
                        if (match_nxt == MW'(LOCK_COUNT)) begin
                            state_nxt  = LOCKED;
                            sel_nxt    = cand;
                            locked_nxt = 1'b1;
                        end
                    end else if (legal) begin
                        cand_nxt  = code;
                        match_nxt = MW'(1);
                    end else begin
                        error_nxt = 1'b1;
                        state_nxt = FIRST;
                    end
                end
                LOCKED: begin
                    if (cnt != sel_per) begin
                        locked_nxt = 1'b0;
                        error_nxt  = 1'b1;
                        if (legal) begin
                            cand_nxt  = code;
                            match_nxt = MW'(1);
                            state_nxt = CHECK;
                        end else begin
                            state_nxt = FIRST;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_ratio_detector.sv
// tb_div_ratio_detector: directed checks of ratio recovery, lock, change, illegal period, timeout and reset
module tb_div_ratio_detector;
    logic       Clock_in  = 1'b0;
    logic       Reset     = 1'b1;
    logic       Clock_div = 1'b0;
    logic [1:0] Sel_out;
    logic       Locked;
    logic [5:0] Period;
    logic       Error;
    int n_vec = 0, n_bad = 0, err_cnt = 0, e0 = 0;

    div_ratio_detector dut (
        .Clock_in (Clock_in),
        .Reset    (Reset),
        .Clock_div(Clock_div),
        .Sel_out  (Sel_out),
        .Locked   (Locked),
        .Period   (Period),
        .Error    (Error)
    );

    always #5 Clock_in = ~Clock_in;

    // count cycles with Error high, sampled away from the active edge
    always @(negedge Clock_in) if (Error) err_cnt++;

    task automatic check(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    // n periods of p Clock_in cycles, each starting with a rise; call at a negedge
    task automatic run(input int p, input int n);
        repeat (n) begin
            Clock_div = 1'b1;
            repeat (p / 2) @(negedge Clock_in);
            Clock_div = 1'b0;
            repeat (p - p / 2) @(negedge Clock_in);
        end
    endtask

    task automatic do_reset();
        Clock_div = 1'b0;
        @(negedge Clock_in);
        Reset = 1'b0;
        @(negedge Clock_in);
        Reset = 1'b1;
    endtask

    initial begin
        #2 Reset = 1'b0;
        #1;
        check("rst_sel", int'(Sel_out), 0);
        check("rst_locked", int'(Locked), 0);
        check("rst_period", int'(Period), 0);
        check("rst_error", int'(Error), 0);
        @(negedge Clock_in);
        Reset = 1'b1;

        // lock at /8 after the 4th rise
        e0 = err_cnt;
        run(8, 3);
        check("t1_nolock_3rises", int'(Locked), 0);
        run(8, 2);
        check("t1_locked", int'(Locked), 1);
        check("t1_sel", int'(Sel_out), 2);
        check("t1_period", int'(Period), 8);
        check("t1_errors", err_cnt - e0, 0);

        // switch to /2 while locked
        e0 = err_cnt;
        run(2, 6);
        repeat (4) @(negedge Clock_in);
        check("t2_errors", err_cnt - e0, 1);
        check("t2_locked", int'(Locked), 1);
        check("t2_sel", int'(Sel_out), 0);
        check("t2_period", int'(Period), 2);

        // illegal period 6
        do_reset();
        e0 = err_cnt;
        run(6, 4);
        check("t3_errors", err_cnt - e0, 3);
        check("t3_locked", int'(Locked), 0);
        check("t3_sel", int'(Sel_out), 0);
        check("t3_period", int'(Period), 6);

        // lock at /16 then stall the divided clock
        do_reset();
        run(16, 5);
        check("t4_locked", int'(Locked), 1);
        check("t4_sel", int'(Sel_out), 3);
        check("t4_period", int'(Period), 16);
        e0 = err_cnt;
        repeat (70) @(negedge Clock_in);
        check("t4_timeout_err", err_cnt - e0, 1);
        check("t4_timeout_locked", int'(Locked), 0);
        check("t4_timeout_sel", int'(Sel_out), 3);
        check("t4_timeout_period", int'(Period), 16);
        repeat (40) @(negedge Clock_in);
        check("t4_no_more_err", err_cnt - e0, 1);

        // lock at /4, short async reset, relock
        do_reset();
        run(4, 6);
        check("t5_locked", int'(Locked), 1);
        check("t5_sel", int'(Sel_out), 1);
        @(negedge Clock_in);
        #1 Reset = 1'b0;
        #1;
        check("t5_async_sel", int'(Sel_out), 0);
        check("t5_async_locked", int'(Locked), 0);
        check("t5_async_period", int'(Period), 0);
        check("t5_async_error", int'(Error), 0);
        #1 Reset = 1'b1;
        @(negedge Clock_in);
        e0 = err_cnt;
        run(4, 6);
        check("t5_relocked", int'(Locked), 1);
        check("t5_resel", int'(Sel_out), 1);
        check("t5_reperiod", int'(Period), 4);
        check("t5_errors", err_cnt - e0, 0);

        // alternating legal periods never lock and never error
        do_reset();
        e0 = err_cnt;
        for (int k = 0; k < 4; k++) begin
            run(4, 1);
            check("t6_period_after4", int'(Period), k == 0 ? 0 : 8);
            run(8, 1);
            check("t6_period_after8", int'(Period), 4);
        end
        check("t6_locked", int'(Locked), 0);
        check("t6_sel", int'(Sel_out), 0);
        check("t6_errors", err_cnt - e0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
